// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
//   sw_state_t : FSM state encoding (IDLE=0, RUN=1, PAUSE=2, HOLD=3)
//   bcd_t      : one 4-bit BCD decade digit
//   BCD_MAX    : largest legal digit value
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    HOLD  = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decade digit counting 0..9.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   en         : advance the digit by one on this edge
//   clr        : synchronous return to zero (wins over en)
//   digit      : current digit value
//   carry      : en while the digit sits at 9 (feeds the next decade)
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output bcd_t digit,
  output logic carry
);

  // Wraps 9 -> 0 so the digit can never hold 0xA..0xF.
  function automatic bcd_t bcd_inc(input bcd_t d);
    if (d >= BCD_MAX) begin
      return '0;
    end
    return d + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (en) begin
      digit <= bcd_inc(digit);
    end
  end

  assign carry = en && (digit == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch controller (00..99).
// Parameter:
//   TICK_DIV   : clock cycles per count increment (>= 1)
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   start_stop : one-cycle pulse, start / stop / resume
//   lap        : one-cycle pulse, freeze / unfreeze the display
//   clear      : one-cycle pulse, return to zero (only acts in PAUSE)
//   disp       : BCD display, [7:4] tens, [3:0] ones
//   state      : FSM state encoding
//   running    : high in RUN or HOLD
//   wrap       : one-cycle pulse after the 99 -> 00 rollover
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 4
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  output logic [7:0] disp,
  output logic [1:0] state,
  output logic       running,
  output logic       wrap
);

  localparam int PRESC_W = ($clog2(TICK_DIV) > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  sw_state_t          state_q;
  sw_state_t          state_d;
  logic               presc_clr;
  logic               lap_capture;
  logic               count_clr;
  logic [PRESC_W-1:0] presc_q;
  logic               counting;
  logic               tick;
  bcd_t               ones;
  bcd_t               tens;
  logic               ones_carry;
  logic               tens_carry;
  logic [7:0]         lap_reg;
  logic               wrap_p1;

  // Counting is decided by the pre-edge state, so the edge leaving
  // RUN/HOLD still counts and the edge entering RUN does not.
  assign counting = (state_q == RUN) || (state_q == HOLD);
  assign tick     = counting && (presc_q == PRESC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority clear > start_stop > lap; clear only has an effect in PAUSE.
  always_comb begin
    state_d     = state_q;
    presc_clr   = 1'b0;
    lap_capture = 1'b0;
    count_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_stop) begin
          state_d   = RUN;
          presc_clr = 1'b1;
        end
      end
      RUN: begin
        if (start_stop) begin
          state_d = PAUSE;
        end else if (lap) begin
          state_d     = HOLD;
          lap_capture = 1'b1;
        end
      end
      HOLD: begin
        if (start_stop) begin
          state_d = PAUSE;
        end else if (lap) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (clear) begin
          state_d   = IDLE;
          count_clr = 1'b1;
          presc_clr = 1'b1;
        end else if (start_stop) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler holds its phase through PAUSE so resumed runs stay exact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (presc_clr) begin
      presc_q <= '0;
    end else if (counting) begin
      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
    end
  end

  bcd_digit u_ones (
    .clk   (clk),
    .reset (reset),
    .en    (tick),
    .clr   (count_clr),
    .digit (ones),
    .carry (ones_carry)
  );

  bcd_digit u_tens (
    .clk   (clk),
    .reset (reset),
    .en    (ones_carry),
    .clr   (count_clr),
    .digit (tens),
    .carry (tens_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lap_reg <= 8'h00;
    end else if (lap_capture) begin
      lap_reg <= {tens, ones};
    end
  end

  // Tens carry-out registered: high for the cycle showing 00 after 99.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrap_p1 <= 1'b0;
    end else begin
      wrap_p1 <= tens_carry;
    end
  end

  assign disp    = (state_q == HOLD) ? lap_reg : {tens, ones};
  assign state   = state_q;
  assign running = counting;
  assign wrap    = wrap_p1;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;
  localparam int         T0      = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       reset1 = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] disp0, disp1;
  logic [1:0] state0, state1;
  logic       running0, running1, wrap0, wrap1;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp(disp0), .state(state0), .running(running0), .wrap(wrap0)
  );

  stopwatch_ctrl #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset1), .start_stop(start_stop), .lap(lap), .clear(clear),
    .disp(disp1), .state(state1), .running(running1), .wrap(wrap1)
  );

  typedef struct {
    string      name;
    int         which;
    logic [7:0] disp;
    logic [1:0] st;
    logic       run;
    logic       wrp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model of dut0 (TICK_DIV=2), count held as a plain integer.
  int         m_cnt, m_pre, m_lap;
  logic [1:0] m_st;
  logic       m_wrap;

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic mreset();
    m_cnt = 0; m_pre = 0; m_lap = 0; m_st = S_IDLE; m_wrap = 1'b0;
  endtask

  task automatic mstep(input logic ss, input logic lp, input logic cl);
    int         ncnt, npre;
    logic [1:0] nst;
    logic       nwrap;
    ncnt = m_cnt; npre = m_pre; nst = m_st; nwrap = 1'b0;
    if (m_st == S_RUN || m_st == S_HOLD) begin
      if (m_pre == T0 - 1) begin
        npre = 0;
        if (m_cnt == 99) begin ncnt = 0; nwrap = 1'b1; end
        else ncnt = m_cnt + 1;
      end else begin
        npre = m_pre + 1;
      end
    end
    case (m_st)
      S_IDLE:  if (ss) begin nst = S_RUN; npre = 0; end
      S_RUN:   if (ss) nst = S_PAUSE;
               else if (lp) begin nst = S_HOLD; m_lap = m_cnt; end
      S_HOLD:  if (ss) nst = S_PAUSE; else if (lp) nst = S_RUN;
      default: if (cl) begin nst = S_IDLE; ncnt = 0; npre = 0; end
               else if (ss) nst = S_RUN;
    endcase
    m_cnt = ncnt; m_pre = npre; m_st = nst; m_wrap = nwrap;
  endtask

  task automatic push_hand(input string n, input int w, input logic [7:0] d,
                           input logic [1:0] s, input logic r, input logic wr);
    exp_t e;
    e.name = n; e.which = w; e.disp = d; e.st = s; e.run = r; e.wrp = wr;
    q.push_back(e);
  endtask

  task automatic push_model(input string n);
    logic [7:0] d;
    d = (m_st == S_HOLD) ? to_bcd(m_lap) : to_bcd(m_cnt);
    push_hand(n, 0, d, m_st, (m_st == S_RUN) || (m_st == S_HOLD), m_wrap);
  endtask

  // Inputs change 1 ns after the rising edge and are sampled at the next one.
  task automatic tick(input logic ss, input logic lp, input logic cl);
    start_stop = ss; lap = lp; clear = cl;
    @(posedge clk);
    #1;
    start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    mstep(ss, lp, cl);
  endtask

  task automatic run(input int n, input string nm);
    for (int i = 0; i < n; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      push_model(nm);
    end
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    mreset();
    #2 reset = 1'b0;
  endtask

  // Monitor: drains the scoreboard shortly after each batch of expectations.
  initial begin : monitor
    exp_t       e;
    logic [7:0] ad;
    logic [1:0] as;
    logic       ar, aw;
    forever begin
      wait (q.size() > 0);
      #1;
      while (q.size() > 0) begin
        e = q.pop_front();
        if (e.which == 0) begin ad = disp0; as = state0; ar = running0; aw = wrap0; end
        else begin ad = disp1; as = state1; ar = running1; aw = wrap1; end
        checks++;
        if (!(ad === e.disp && as === e.st && ar === e.run && aw === e.wrp)) begin
          failures++;
          $display("FAIL %s: got disp=%h state=%0d running=%b wrap=%b, want disp=%h state=%0d running=%b wrap=%b",
                   e.name, ad, as, ar, aw, e.disp, e.st, e.run, e.wrp);
        end
        checks++;
        if (!(ad[7:4] <= 4'd9 && ad[3:0] <= 4'd9)) begin
          failures++;
          $display("FAIL %s_nibble: got disp=%h, want both nibbles <= 9", e.name, ad);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish by 200000 ns, want earlier finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    mreset();
    #1;
    reset = 1'b1;
    reset1 = 1'b1;
    #1;
    push_hand("reset_init", 0, 8'h00, S_IDLE, 1'b0, 1'b0);
    push_hand("reset_init1", 1, 8'h00, S_IDLE, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Run to 34, then reset asynchronously mid-cycle.
    tick(1'b1, 1'b0, 1'b0); push_model("start");
    run(68, "run_to_34");
    push_hand("at_34", 0, 8'h34, S_RUN, 1'b1, 1'b0);
    #3 reset = 1'b1;
    mreset();
    #1 push_hand("async_reset", 0, 8'h00, S_IDLE, 1'b0, 1'b0);
    #3 reset = 1'b0;
    tick(1'b1, 1'b0, 1'b0); push_hand("rst_start", 0, 8'h00, S_RUN, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0); push_hand("rst_pre", 0, 8'h00, S_RUN, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0); push_hand("rst_first_inc", 0, 8'h01, S_RUN, 1'b1, 1'b0);

    // Carry 09 -> 10 and full wrap after 200 cycles.
    pulse_reset();
    tick(1'b1, 1'b0, 1'b0); push_model("carry_start");
    run(20, "carry_run");
    push_hand("carry_10", 0, 8'h10, S_RUN, 1'b1, 1'b0);
    run(179, "wrap_run");
    push_hand("wrap_99", 0, 8'h99, S_RUN, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0); push_hand("wrap_rollover", 0, 8'h00, S_RUN, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b0); push_hand("wrap_drop", 0, 8'h00, S_RUN, 1'b1, 1'b0);

    // Lap freeze and release.
    pulse_reset();
    tick(1'b1, 1'b0, 1'b0); push_model("lap_start");
    run(10, "lap_run");
    push_hand("lap_at_05", 0, 8'h05, S_RUN, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0); push_hand("lap_hold", 0, 8'h05, S_HOLD, 1'b1, 1'b0);
    run(7, "lap_held");
    push_hand("lap_held_end", 0, 8'h05, S_HOLD, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0); push_hand("lap_release", 0, 8'h09, S_RUN, 1'b1, 1'b0);

    // Pause, resume on the preserved phase, clear handling.
    pulse_reset();
    tick(1'b1, 1'b0, 1'b0); push_model("pause_start");
    run(14, "pause_run");
    push_hand("at_07", 0, 8'h07, S_RUN, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0); push_hand("pause", 0, 8'h07, S_PAUSE, 1'b0, 1'b0);
    run(10, "paused");
    push_hand("paused_end", 0, 8'h07, S_PAUSE, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0); push_hand("resume", 0, 8'h07, S_RUN, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0); push_hand("resume_phase", 0, 8'h08, S_RUN, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1); push_hand("clear_in_run", 0, 8'h08, S_RUN, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0); push_hand("pause2", 0, 8'h09, S_PAUSE, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1); push_hand("clear_in_pause", 0, 8'h00, S_IDLE, 1'b0, 1'b0);

    // Coinciding commands.
    tick(1'b1, 1'b0, 1'b0); push_model("simul_start");
    run(4, "simul_run");
    push_hand("simul_at_02", 0, 8'h02, S_RUN, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0); push_hand("ss_lap_run", 0, 8'h02, S_PAUSE, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1); push_hand("clr_ss_pause", 0, 8'h00, S_IDLE, 1'b0, 1'b0);

    // TICK_DIV=1 instance counts every RUN cycle.
    reset1 = 1'b0;
    tick(1'b1, 1'b0, 1'b0); push_hand("t1_start", 1, 8'h00, S_RUN, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      push_hand("t1_run", 1, to_bcd(i), S_RUN, 1'b1, 1'b0);
    end
    push_hand("t1_05", 1, 8'h05, S_RUN, 1'b1, 1'b0);

    #5;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
